rv_sdram_bridge: RTL and testbench

RV_SDRAM_BRIDGE -- requirements
Module: rv_sdram_bridge

---
 rtl/rv_sdram_bridge.sv | 120 ++++++++++++
 tb/tb_rv_sdram_bridge.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv_sdram_bridge.sv
// rv_sdram_bridge: 32-bit softcore bus to 16-bit toggle-handshake sdram port; define RV_HALF_SKIP_EN to skip empty write halves
module rv_sdram_bridge (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [22:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic [21:0] rv_addr,
  output logic [15:0] rv_din,
  output logic [1:0]  rv_ds,
  output logic        rv_we,
  output logic        rv_req,
  input  logic        rv_req_ack,
  input  logic [15:0] rv_dout
);
  typedef enum logic [2:0] {SYNC, IDLE, LO_WAIT, HI_WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic rv_req_q, rv_req_d, rv_we_q, rv_we_d, mem_ready_q, mem_ready_d;
  logic [21:0] rv_addr_q, rv_addr_d;
  logic [15:0] rv_din_q, rv_din_d, whi_q, whi_d;
  logic [1:0] rv_ds_q, rv_ds_d;
  logic [20:0] addr_q, addr_d;
  logic [3:0] wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic ack, wr, skip_lo, skip_hi, unused;
  assign ack = rv_req_q == rv_req_ack;
  assign wr = |wstrb_q;
  assign unused = ^mem_addr[1:0];
`ifdef RV_HALF_SKIP_EN
  assign skip_lo = (|mem_wstrb) && mem_wstrb[1:0] == 2'b00;
  assign skip_hi = wr && wstrb_q[3:2] == 2'b00;
`else
  assign skip_lo = 1'b0;
  assign skip_hi = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    rv_req_d = rv_req_q;
    rv_addr_d = rv_addr_q;
    rv_din_d = rv_din_q;
    rv_ds_d = rv_ds_q;
    rv_we_d = rv_we_q;
    mem_ready_d = 1'b0;
    addr_d = addr_q;
    whi_d = whi_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    case (state_q)
      SYNC: state_d = ack ? IDLE : SYNC;
      IDLE: if (mem_valid) begin
        addr_d = mem_addr[22:2];
        whi_d = mem_wdata[31:16];
        wstrb_d = mem_wstrb;
        rv_req_d = ~rv_req_q;
        rv_we_d = |mem_wstrb;
        rv_addr_d = {mem_addr[22:2], skip_lo};
        rv_din_d = skip_lo ? mem_wdata[31:16] : mem_wdata[15:0];
        rv_ds_d = ~|mem_wstrb ? 2'b11 : skip_lo ? mem_wstrb[3:2] : mem_wstrb[1:0];
        state_d = skip_lo ? HI_WAIT : LO_WAIT;
      end
      LO_WAIT: if (ack) begin
        rdata_d[15:0] = wr ? rdata_q[15:0] : rv_dout;
        if (skip_hi) begin
          state_d = RESP;
          mem_ready_d = 1'b1;
        end else begin
          rv_req_d = ~rv_req_q;
          rv_addr_d = {addr_q, 1'b1};
          rv_din_d = whi_q;
          rv_ds_d = wr ? wstrb_q[3:2] : 2'b11;
          state_d = HI_WAIT;
        end
      end
      HI_WAIT: if (ack) begin
        rdata_d[31:16] = wr ? rdata_q[31:16] : rv_dout;
        state_d = RESP;
        mem_ready_d = 1'b1;
      end
      RESP: state_d = IDLE;
      default: state_d = SYNC;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= SYNC;
      rv_req_q <= 1'b0;
      rv_addr_q <= '0;
      rv_din_q <= '0;
      rv_ds_q <= '0;
      rv_we_q <= 1'b0;
      mem_ready_q <= 1'b0;
      addr_q <= '0;
      whi_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rv_req_q <= rv_req_d;
      rv_addr_q <= rv_addr_d;
      rv_din_q <= rv_din_d;
      rv_ds_q <= rv_ds_d;
      rv_we_q <= rv_we_d;
      mem_ready_q <= mem_ready_d;
      addr_q <= addr_d;
      whi_q <= whi_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
    end
  end
  assign rv_req = rv_req_q;
  assign rv_addr = rv_addr_q;
  assign rv_din = rv_din_q;
  assign rv_ds = rv_ds_q;
  assign rv_we = rv_we_q;
  assign mem_ready = mem_ready_q;
  assign mem_rdata = rdata_q;
endmodule

// File: tb/tb_rv_sdram_bridge.sv
// tb_rv_sdram_bridge: randomized scoreboard bench for rv_sdram_bridge against a word-level memory model
module tb_rv_sdram_bridge;
  logic clk = 1'b0, resetn = 1'b0, mem_valid = 1'b0, rv_req_ack = 1'b0;
  logic mem_ready, rv_we, rv_req;
  logic [22:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0, mem_rdata;
  logic [3:0] mem_wstrb = '0;
  logic [21:0] rv_addr;
  logic [15:0] rv_din, rv_dout = '0;
  logic [1:0] rv_ds;
  always #5 clk = ~clk;
  rv_sdram_bridge dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .rv_addr(rv_addr), .rv_din(rv_din), .rv_ds(rv_ds), .rv_we(rv_we),
    .rv_req(rv_req), .rv_req_ack(rv_req_ack), .rv_dout(rv_dout)
  );
`ifdef RV_HALF_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif
  typedef struct packed {
    logic [21:0] a;
    logic we;
    logic [1:0] ds;
    logic [15:0] din;
  } op_t;
  op_t exp_ops[$];
  logic [31:0] exp_rd[$];
  logic [31:0] ref_mem [int];
  logic [15:0] sd_mem [int];
  logic [31:0] last_rd = '0;
  int n_chk = 0, n_pass = 0, dly = -1;
  bit hold = 1'b0;
  function automatic logic [15:0] init_hw(input int a);
    return a[15:0] ^ 16'hc3a5;
  endfunction
  function automatic logic [15:0] sd_rd(input int a);
    return sd_mem.exists(a) ? sd_mem[a] : init_hw(a);
  endfunction
  function automatic logic [31:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : {init_hw(2 * w + 1), init_hw(2 * w)};
  endfunction
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask
  function automatic void push_exp(input logic [22:0] a, input logic [31:0] d, input logic [3:0] s);
    int w = int'(a[22:2]);
    logic [31:0] cur = ref_rd(w);
    op_t o;
    if (s == 4'b0000) begin
      for (int h = 0; h < 2; h++) begin
        o = '{a: 22'(2 * w + h), we: 1'b0, ds: 2'b11, din: 16'h0000};
        exp_ops.push_back(o);
      end
      last_rd = cur;
    end else begin
      for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
      ref_mem[w] = cur;
      for (int h = 0; h < 2; h++) begin
        o = '{a: 22'(2 * w + h), we: 1'b1, ds: s[2*h +: 2], din: d[16*h +: 16]};
        if (s[2*h +: 2] != 2'b00 || !SKIP) exp_ops.push_back(o);
      end
    end
    exp_rd.push_back(last_rd);
  endfunction
  initial begin
    logic prev = 1'b0;
    op_t e, g;
    forever begin
      @(posedge clk);
      #1;
      if (resetn && rv_req != prev) begin
        if (exp_ops.size() == 0) check("op_unexpected", 64'(exp_ops.size()), 64'd1);
        else begin
          e = exp_ops.pop_front();
          g = '{a: rv_addr, we: rv_we, ds: rv_ds, din: rv_we ? rv_din : 16'h0000};
          check("rv_op", 64'(g), 64'(e));
        end
      end
      prev = rv_req;
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (resetn && mem_ready) begin
      if (exp_rd.size() == 0) check("ready_unexpected", 64'(exp_rd.size()), 64'd1);
      else check("mem_rdata", 64'(mem_rdata), 64'(exp_rd.pop_front()));
    end
  end
  initial begin
    bit pend = 1'b0;
    int cnt = 0;
    op_t c;
    logic [15:0] m;
    forever begin
      @(posedge clk);
      #2;
      if (!resetn || hold) pend = 1'b0;
      else if (pend) begin
        if (cnt > 0) cnt--;
        else begin
          check("rv_stable", 64'({rv_addr, rv_we, rv_ds, rv_din}), 64'(c));
          if (c.we) begin
            m = sd_rd(int'(c.a));
            if (c.ds[0]) m[7:0] = c.din[7:0];
            if (c.ds[1]) m[15:8] = c.din[15:8];
            sd_mem[int'(c.a)] = m;
          end else rv_dout = sd_rd(int'(c.a));
          rv_req_ack = rv_req;
          pend = 1'b0;
        end
      end else if (rv_req != rv_req_ack) begin
        c = '{a: rv_addr, we: rv_we, ds: rv_ds, din: rv_din};
        cnt = dly < 0 ? int'($urandom_range(0, 3)) : dly;
        pend = 1'b1;
      end
    end
  end
  task automatic issue(input logic [22:0] a, input logic [31:0] d, input logic [3:0] s);
    push_exp(a, d, s);
    mem_addr = a;
    mem_wdata = d;
    mem_wstrb = s;
    mem_valid = 1'b1;
  endtask
  task automatic finish_x(input bit drop, input bit lat);
    int n = 0;
    logic r0 = rv_req;
    while (!mem_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (drop && rv_req != r0) begin
        mem_valid = 1'b0;
        mem_addr = 23'($urandom);
        mem_wdata = $urandom;
        mem_wstrb = 4'($urandom);
      end
    end
    check("ready_seen", 64'(mem_ready), 64'd1);
    if (lat) check("ready_latency", 64'(n), 64'd5);
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
  endtask
  initial begin
    logic [22:0] a;
    logic [3:0] s;
    #1;
    check("reset_rv", 64'({rv_req, rv_we, rv_ds, rv_addr, rv_din}), 64'd0);
    check("reset_mem", 64'({mem_ready, mem_rdata}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    sd_mem[32'h100] = 16'h1234;
    sd_mem[32'h101] = 16'habcd;
    ref_mem[32'h80] = 32'habcd1234;
    dly = 1;
    issue(23'h000200, 32'h0, 4'b0000);
    finish_x(1'b0, 1'b0);
    dly = -1;
    issue(23'h000010, 32'hdeadbeef, 4'b1111);
    finish_x(1'b0, 1'b0);
    issue(23'h000010, 32'h12345678, 4'b1100);
    finish_x(1'b0, 1'b0);
    issue(23'h000010, 32'h0, 4'b0000);
    finish_x(1'b0, 1'b0);
    dly = 0;
    issue(23'h000204, 32'h0, 4'b0000);
    finish_x(1'b0, 1'b1);
    issue(23'h000204, 32'h0badf00d, 4'b1111);
    finish_x(1'b0, 1'b1);
    dly = -1;
    issue(23'h000014, 32'hcafef00d, 4'b1111);
    finish_x(1'b1, 1'b0);
    issue(23'h000014, 32'h0, 4'b0000);
    finish_x(1'b1, 1'b0);
    for (int i = 0; i < 60; i++) begin
      a = (23'($urandom_range(0, 7)) << 2) | 23'($urandom_range(0, 3));
      s = $urandom_range(0, 2) == 0 ? 4'b0000 : 4'($urandom);
      issue(a, $urandom, s);
      finish_x($urandom_range(0, 3) == 0, 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    hold = 1'b1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    rv_req_ack = 1'b0;
    resetn = 1'b1;
    hold = 1'b0;
    issue(23'h000300, 32'h0, 4'b0000);
    begin
      int n = 0;
      while (exp_ops.size() != 0 && n < 50) begin
        @(posedge clk);
        #3;
        n++;
      end
    end
    hold = 1'b1;
    check("abort_setup", 64'({rv_req, rv_req_ack}), 64'b01);
    resetn = 1'b0;
    #1;
    check("abort_rv", 64'({rv_req, rv_we, rv_ds, rv_addr, rv_din}), 64'd0);
    check("abort_mem", 64'({mem_ready, mem_rdata}), 64'd0);
    exp_ops.delete();
    exp_rd.delete();
    last_rd = '0;
    mem_valid = 1'b0;
    @(posedge clk);
    #3;
    resetn = 1'b1;
    issue(23'h000208, 32'h0, 4'b0000);
    repeat (5) @(posedge clk);
    #1;
    check("sync_hold", 64'({rv_req, rv_req_ack}), 64'b01);
    rv_req_ack = 1'b0;
    hold = 1'b0;
    finish_x(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("ops_drained", 64'(exp_ops.size()), 64'd0);
    check("rd_drained", 64'(exp_rd.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
